// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg
// Shared definitions for the DRAM port arbiter: the command-channel state
// encoding and the port-ID width helper. The command struct depends on the
// arbiter's width parameters and is declared inside dram_port_arbiter.
package dram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Port-ID width for a given port count; never less than one bit.
    function automatic int id_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/dram_arb_tag_fifo.sv
// dram_arb_tag_fifo
// Holds the issuing port ID of every outstanding DRAM read, in issue order,
// so returning read data can be steered back to the right client.
// Ports:
//   clock, reset      DRAM user clock, synchronous active-high reset
//   push, push_id     enqueue the ID of a newly granted read
//   pop, pop_id       dequeue; pop_id is the head entry (valid when !empty)
//   count             number of entries held (0..DEPTH)
//   empty, full       occupancy flags
// The caller must not push when full or pop when empty.
module dram_arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_id,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_id,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_id;
    end

    assign pop_id = mem[rd_ptr];
    assign empty  = (count == '0);
    assign full   = (count == (PTR_W + 1)'(DEPTH));

endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
// Arbitrates NUM_PORTS client request ports onto the single DRAM wrapper
// command channel and returns in-order read data to the issuing port.
// Ports:
//   clock, reset                       DRAM user clock, sync active-high reset
//   port_ren/port_wen                  per-port requests, held until port_ready
//   port_addr/port_wdata/port_wmask    packed per-port payloads (port i at i*W)
//   port_ready                         one-hot accept strobe (combinational)
//   port_rvalid, port_rdata            registered one-hot read return + data
//   dram_init_calib_complete           no grants while low
//   dram_ren/wen/addr/wdata/wmask      registered command to the wrapper
//   dram_busy                          wrapper stalls the current command
//   dram_rdata, dram_rdata_valid       in-order read data from the wrapper
//   rd_err                             sticky: read data with nothing outstanding
// Build option:
//   DRAM_ARB_FIXED_PRIO_EN  port 0 always wins when eligible; the remaining
//                           ports round-robin among themselves.
//
// state | meaning
// IDLE  | command register empty, any eligible request may load it
// HOLD  | command presented to DRAM; reloads only in a cycle it is accepted
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int RD_DEPTH   = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            port_ren,
    input  logic [NUM_PORTS-1:0]            port_wen,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0] port_wmask,
    output logic [NUM_PORTS-1:0]            port_ready,
    output logic [NUM_PORTS-1:0]            port_rvalid,
    output logic [DATA_WIDTH-1:0]           port_rdata,
    input  logic                            dram_init_calib_complete,
    output logic                            dram_ren,
    output logic                            dram_wen,
    output logic [ADDR_WIDTH-1:0]           dram_addr,
    output logic [DATA_WIDTH-1:0]           dram_wdata,
    output logic [MASK_WIDTH-1:0]           dram_wmask,
    input  logic                            dram_busy,
    input  logic [DATA_WIDTH-1:0]           dram_rdata,
    input  logic                            dram_rdata_valid,
    output logic                            rd_err
);

    localparam int ID_WIDTH  = id_width(NUM_PORTS);
    localparam int CNT_WIDTH = $clog2(RD_DEPTH) + 1;

    typedef struct packed {
        logic                  ren;
        logic                  wen;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [MASK_WIDTH-1:0] wmask;
        logic [ID_WIDTH-1:0]   id;
    } cmd_t;

    arb_state_t            state_q, state_d;
    cmd_t                  cmd_q, cmd_d;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [NUM_PORTS-1:0]  eligible;
    logic                  grant_vld;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  can_load;
    logic                  load;
    logic                  sel_wen;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [MASK_WIDTH-1:0] sel_wmask;

    logic [CNT_WIDTH-1:0]  rd_cnt;
    logic [ID_WIDTH-1:0]   tag_head;
    logic                  tag_empty;
    logic                  tag_full;
    logic                  tag_push;
    logic                  tag_pop;
    logic [NUM_PORTS-1:0]  rvalid_onehot;

    // A write wins over a simultaneous read on the same port; reads need a
    // free tag slot.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = port_wen[i] | (port_ren[i] & (rd_cnt < CNT_WIDTH'(RD_DEPTH)));
        end
    end

    // Search starts just after the last winner so every port gets a turn.
`ifdef DRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        if (eligible[0]) begin
            grant_vld = 1'b1;
        end else begin
            for (int k = 1; k < NUM_PORTS; k++) begin
                idx = 1 + ((int'(last_grant) - 1 + k) % (NUM_PORTS - 1));
                for (int i = 1; i < NUM_PORTS; i++) begin
                    if (!grant_vld && (i == idx) && eligible[i]) begin
                        grant_vld = 1'b1;
                        grant_id  = ID_WIDTH'(i);
                    end
                end
            end
        end
    end
`else
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last_grant) + k) % NUM_PORTS;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!grant_vld && (i == idx) && eligible[i]) begin
                    grant_vld = 1'b1;
                    grant_id  = ID_WIDTH'(i);
                end
            end
        end
    end
`endif

    always_comb begin
        sel_wen   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (i == int'(grant_id)) begin
                sel_wen   = port_wen[i];
                sel_addr  = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wmask = port_wmask[i*MASK_WIDTH +: MASK_WIDTH];
            end
        end
    end

    // The command register reloads when empty, or in the same cycle the
    // wrapper accepts the current command, giving one command per cycle.
    always_comb begin
        state_d  = state_q;
        can_load = dram_init_calib_complete & ((state_q == IDLE) | ~dram_busy);
        load     = 1'b0;
        cmd_d    = cmd_q;
        port_ready = '0;
        if (can_load && grant_vld) begin
            load    = 1'b1;
            state_d = HOLD;
            cmd_d   = '{ren: ~sel_wen, wen: sel_wen, addr: sel_addr,
                        wdata: sel_wdata, wmask: sel_wmask, id: grant_id};
            for (int i = 0; i < NUM_PORTS; i++) begin
                port_ready[i] = (i == int'(grant_id));
            end
        end else if ((state_q == HOLD) && !dram_busy) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            last_grant <= ID_WIDTH'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
`ifdef DRAM_ARB_FIXED_PRIO_EN
            if (load && (grant_id != '0)) last_grant <= grant_id;
`else
            if (load) last_grant <= grant_id;
`endif
        end
    end

    assign dram_ren   = (state_q == HOLD) & cmd_q.ren;
    assign dram_wen   = (state_q == HOLD) & cmd_q.wen;
    assign dram_addr  = cmd_q.addr;
    assign dram_wdata = cmd_q.wdata;
    assign dram_wmask = cmd_q.wmask;

    // Reads are tagged at grant time; the wrapper returns data in issue order.
    assign tag_push = load & ~sel_wen & ~tag_full;
    assign tag_pop  = dram_rdata_valid & ~tag_empty;

    dram_arb_tag_fifo #(
        .DEPTH (RD_DEPTH),
        .WIDTH (ID_WIDTH)
    ) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (tag_push),
        .push_id (grant_id),
        .pop     (tag_pop),
        .pop_id  (tag_head),
        .count   (rd_cnt),
        .empty   (tag_empty),
        .full    (tag_full)
    );

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rvalid_onehot[i] = (i == int'(tag_head));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            port_rvalid <= '0;
            port_rdata  <= '0;
            rd_err      <= 1'b0;
        end else begin
            port_rvalid <= '0;
            if (dram_rdata_valid) begin
                if (tag_empty) begin
                    rd_err <= 1'b1;
                end else begin
                    port_rvalid <= rvalid_onehot;
                    port_rdata  <= dram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 27;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam int NV = 30;

    localparam logic [AW-1:0] ADDR0  = 27'h100;
    localparam logic [AW-1:0] ADDR1  = 27'h200;
    localparam logic [AW-1:0] ADDR1B = 27'h300;
    localparam logic [DW-1:0] WD0    = 128'hD0D0;
    localparam logic [DW-1:0] WD1    = 128'hD1D1;
    localparam logic [DW-1:0] WD1B   = 128'hB1B1;
    localparam logic [MW-1:0] WM0    = 16'h00FF;
    localparam logic [MW-1:0] WM1    = 16'hFF00;

    logic              clock = 1'b0;
    logic              reset;
    logic [NP-1:0]     port_ren;
    logic [NP-1:0]     port_wen;
    logic [AW-1:0]     addr0, addr1;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NP*AW-1:0]  port_addr;
    logic [NP*DW-1:0]  port_wdata;
    logic [NP*MW-1:0]  port_wmask;
    logic [NP-1:0]     port_ready;
    logic [NP-1:0]     port_rvalid;
    logic [DW-1:0]     port_rdata;
    logic              calib;
    logic              dram_ren, dram_wen;
    logic [AW-1:0]     dram_addr;
    logic [DW-1:0]     dram_wdata;
    logic [MW-1:0]     dram_wmask;
    logic              dram_busy;
    logic [DW-1:0]     dram_rdata;
    logic              dram_rdata_valid;
    logic              rd_err;

    int total = 0;
    int bad   = 0;

    assign port_addr  = {addr1, addr0};
    assign port_wdata = {wdata1, wdata0};
    assign port_wmask = {WM1, WM0};

    always #5 clock = ~clock;

    dram_port_arbiter dut (
        .clock                    (clock),
        .reset                    (reset),
        .port_ren                 (port_ren),
        .port_wen                 (port_wen),
        .port_addr                (port_addr),
        .port_wdata               (port_wdata),
        .port_wmask               (port_wmask),
        .port_ready               (port_ready),
        .port_rvalid              (port_rvalid),
        .port_rdata               (port_rdata),
        .dram_init_calib_complete (calib),
        .dram_ren                 (dram_ren),
        .dram_wen                 (dram_wen),
        .dram_addr                (dram_addr),
        .dram_wdata               (dram_wdata),
        .dram_wmask               (dram_wmask),
        .dram_busy                (dram_busy),
        .dram_rdata               (dram_rdata),
        .dram_rdata_valid         (dram_rdata_valid),
        .rd_err                   (rd_err)
    );

    typedef struct {
        logic       calib;
        logic [1:0] ren;
        logic [1:0] wen;
        logic       dvalid;
        logic [7:0] drdata;
        logic [1:0] exp_ready;
        logic       exp_ren;
        logic       exp_wen;
        int         exp_port;
        logic [1:0] exp_rvalid;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic c, input logic [1:0] r, input logic [1:0] w,
                                input logic dv, input logic [7:0] dd,
                                input logic [1:0] er, input logic edr, input logic edw,
                                input int ep, input logic [1:0] erv, input logic [7:0] erd,
                                input logic ee);
        vec_t v;
        v.calib = c;  v.ren = r;  v.wen = w;  v.dvalid = dv;  v.drdata = dd;
        v.exp_ready = er;  v.exp_ren = edr;  v.exp_wen = edw;  v.exp_port = ep;
        v.exp_rvalid = erv;  v.exp_rdata = erd;  v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;  calib = 1'b0;  port_ren = '0;  port_wen = '0;
        addr0 = ADDR0; addr1 = ADDR1; wdata0 = WD0; wdata1 = WD1;
        dram_busy = 1'b0;  dram_rdata = '0;  dram_rdata_valid = 1'b0;

        //          calib ren    wen    dv  dd     ready  dren dwen port rvalid rdata err
        // calibration gate, then alternating writes
        vecs[0]  = mk(0, 2'b00, 2'b11, 0, 8'h00, 2'b00, 0, 0, 0, 2'b00, 8'h00, 0);
        vecs[1]  = mk(0, 2'b00, 2'b11, 0, 8'h00, 2'b00, 0, 0, 0, 2'b00, 8'h00, 0);
        vecs[2]  = mk(1, 2'b00, 2'b11, 0, 8'h00, 2'b01, 0, 0, 0, 2'b00, 8'h00, 0);
        vecs[3]  = mk(1, 2'b00, 2'b11, 0, 8'h00, 2'b10, 0, 1, 0, 2'b00, 8'h00, 0);
        vecs[4]  = mk(1, 2'b00, 2'b11, 0, 8'h00, 2'b01, 0, 1, 1, 2'b00, 8'h00, 0);
        vecs[5]  = mk(1, 2'b00, 2'b11, 0, 8'h00, 2'b10, 0, 1, 0, 2'b00, 8'h00, 0);
        vecs[6]  = mk(1, 2'b00, 2'b00, 0, 8'h00, 2'b00, 0, 1, 1, 2'b00, 8'h00, 0);
        vecs[7]  = mk(1, 2'b00, 2'b00, 0, 8'h00, 2'b00, 0, 0, 0, 2'b00, 8'h00, 0);
        // port 0 fills all four read slots, port 1 stalls until one returns
        vecs[8]  = mk(1, 2'b01, 2'b00, 0, 8'h00, 2'b01, 0, 0, 0, 2'b00, 8'h00, 0);
        vecs[9]  = mk(1, 2'b01, 2'b00, 0, 8'h00, 2'b01, 1, 0, 0, 2'b00, 8'h00, 0);
        vecs[10] = mk(1, 2'b01, 2'b00, 0, 8'h00, 2'b01, 1, 0, 0, 2'b00, 8'h00, 0);
        vecs[11] = mk(1, 2'b01, 2'b00, 0, 8'h00, 2'b01, 1, 0, 0, 2'b00, 8'h00, 0);
        vecs[12] = mk(1, 2'b10, 2'b00, 0, 8'h00, 2'b00, 1, 0, 0, 2'b00, 8'h00, 0);
        vecs[13] = mk(1, 2'b10, 2'b00, 1, 8'hA1, 2'b00, 0, 0, 0, 2'b00, 8'h00, 0);
        vecs[14] = mk(1, 2'b10, 2'b00, 0, 8'h00, 2'b10, 0, 0, 0, 2'b01, 8'hA1, 0);
        vecs[15] = mk(1, 2'b00, 2'b00, 0, 8'h00, 2'b00, 1, 0, 1, 2'b00, 8'h00, 0);
        vecs[16] = mk(1, 2'b00, 2'b00, 1, 8'hA2, 2'b00, 0, 0, 0, 2'b00, 8'h00, 0);
        vecs[17] = mk(1, 2'b00, 2'b00, 1, 8'hA3, 2'b00, 0, 0, 0, 2'b01, 8'hA2, 0);
        vecs[18] = mk(1, 2'b00, 2'b00, 1, 8'hA4, 2'b00, 0, 0, 0, 2'b01, 8'hA3, 0);
        vecs[19] = mk(1, 2'b00, 2'b00, 1, 8'hB1, 2'b00, 0, 0, 0, 2'b01, 8'hA4, 0);
        vecs[20] = mk(1, 2'b00, 2'b00, 0, 8'h00, 2'b00, 0, 0, 0, 2'b10, 8'hB1, 0);
        // interleaved reads 0,1,0 with a push and pop in the same cycle
        vecs[21] = mk(1, 2'b01, 2'b00, 0, 8'h00, 2'b01, 0, 0, 0, 2'b00, 8'h00, 0);
        vecs[22] = mk(1, 2'b10, 2'b00, 0, 8'h00, 2'b10, 1, 0, 0, 2'b00, 8'h00, 0);
        vecs[23] = mk(1, 2'b01, 2'b00, 1, 8'h0A, 2'b01, 1, 0, 1, 2'b00, 8'h00, 0);
        vecs[24] = mk(1, 2'b00, 2'b00, 1, 8'h0B, 2'b00, 1, 0, 0, 2'b01, 8'h0A, 0);
        vecs[25] = mk(1, 2'b00, 2'b00, 1, 8'h0C, 2'b00, 0, 0, 0, 2'b10, 8'h0B, 0);
        vecs[26] = mk(1, 2'b00, 2'b00, 0, 8'h00, 2'b00, 0, 0, 0, 2'b01, 8'h0C, 0);
        // stray read data sets the sticky error and returns nothing
        vecs[27] = mk(1, 2'b00, 2'b00, 1, 8'hEE, 2'b00, 0, 0, 0, 2'b00, 8'h00, 0);
        vecs[28] = mk(1, 2'b00, 2'b00, 0, 8'h00, 2'b00, 0, 0, 0, 2'b00, 8'h00, 1);
        vecs[29] = mk(1, 2'b00, 2'b00, 0, 8'h00, 2'b00, 0, 0, 0, 2'b00, 8'h00, 1);

        next_cycle();
        next_cycle();
        #2;
        chk("rst dram_ren", dram_ren, 0);
        chk("rst dram_wen", dram_wen, 0);
        chk("rst dram_addr", dram_addr, 0);
        chk("rst dram_wdata", dram_wdata, 0);
        chk("rst dram_wmask", dram_wmask, 0);
        chk("rst port_ready", port_ready, 0);
        chk("rst port_rvalid", port_rvalid, 0);
        chk("rst port_rdata", port_rdata, 0);
        chk("rst rd_err", rd_err, 0);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            calib            = vecs[i].calib;
            port_ren         = vecs[i].ren;
            port_wen         = vecs[i].wen;
            dram_rdata_valid = vecs[i].dvalid;
            dram_rdata       = {120'h0, vecs[i].drdata};
            #2;
            chk($sformatf("v%0d port_ready", i), port_ready, vecs[i].exp_ready);
            chk($sformatf("v%0d dram_ren", i), dram_ren, vecs[i].exp_ren);
            chk($sformatf("v%0d dram_wen", i), dram_wen, vecs[i].exp_wen);
            if (vecs[i].exp_ren || vecs[i].exp_wen)
                chk($sformatf("v%0d dram_addr", i), dram_addr,
                    (vecs[i].exp_port == 1) ? ADDR1 : ADDR0);
            if (vecs[i].exp_wen) begin
                chk($sformatf("v%0d dram_wdata", i), dram_wdata,
                    (vecs[i].exp_port == 1) ? WD1 : WD0);
                chk($sformatf("v%0d dram_wmask", i), dram_wmask,
                    (vecs[i].exp_port == 1) ? WM1 : WM0);
            end
            chk($sformatf("v%0d port_rvalid", i), port_rvalid, vecs[i].exp_rvalid);
            if (vecs[i].exp_rvalid != 2'b00)
                chk($sformatf("v%0d port_rdata", i), port_rdata, {120'h0, vecs[i].exp_rdata});
            chk($sformatf("v%0d rd_err", i), rd_err, vecs[i].exp_err);
            next_cycle();
        end
        port_ren = '0;  port_wen = '0;  dram_rdata_valid = 1'b0;

        // reset clears the sticky error
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #2;
        chk("err cleared", rd_err, 0);
        next_cycle();

        // reset with a read in flight, then late data from the wrapper
        port_ren = 2'b01;
        #2;
        chk("late rd ready", port_ready, 2'b01);
        next_cycle();
        port_ren = 2'b00;
        #2;
        chk("late rd dram_ren", dram_ren, 1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #2;
        chk("mid rst dram_ren", dram_ren, 0);
        chk("mid rst rd_err", rd_err, 0);
        dram_rdata_valid = 1'b1;
        dram_rdata       = 128'h55;
        next_cycle();
        dram_rdata_valid = 1'b0;
        #2;
        chk("late data rd_err", rd_err, 1);
        chk("late data rvalid", port_rvalid, 2'b00);
        next_cycle();

        // port 1 write stalled by dram_busy: payload must hold steady
        port_wen = 2'b10;
        #2;
        chk("busy grant", port_ready, 2'b10);
        next_cycle();
        addr1     = ADDR1B;
        wdata1    = WD1B;
        dram_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk($sformatf("busy%0d ready", k), port_ready, 2'b00);
            chk($sformatf("busy%0d dram_wen", k), dram_wen, 1);
            chk($sformatf("busy%0d dram_addr", k), dram_addr, ADDR1);
            chk($sformatf("busy%0d dram_wdata", k), dram_wdata, WD1);
            next_cycle();
        end
        dram_busy = 1'b0;
        #2;
        chk("unbusy ready", port_ready, 2'b10);
        chk("unbusy dram_addr", dram_addr, ADDR1);
        next_cycle();
        port_wen = 2'b00;
        #2;
        chk("second wr dram_wen", dram_wen, 1);
        chk("second wr dram_addr", dram_addr, ADDR1B);
        chk("second wr dram_wdata", dram_wdata, WD1B);
        next_cycle();
        #2;
        chk("drained dram_wen", dram_wen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
